// File: rtl/reg_file_mp.sv
// Multi-port register file: NR combinational read ports, two clocked write ports,
// optional hardwired zero register, optional write-to-read bypass and a busy scoreboard.
module reg_file_mp #(
  parameter int W         = 8,
  parameter int D         = 5,
  parameter int NR        = 2,
  parameter int ZERO_MODE = 1,
  parameter int BYPASS    = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [1:0]        we,
  input  logic [2*D-1:0]    waddr,
  input  logic [2*W-1:0]    wdata,
  input  logic              mark_en,
  input  logic [D-1:0]      mark_addr,
  input  logic [NR*D-1:0]   raddr,
  output logic [NR*W-1:0]   rdata,
  output logic [NR-1:0]     rbusy
);
  localparam int N = 2**D;

  logic [W-1:0] mem_q [N];
  logic [W-1:0] mem_d [N];
  logic [N-1:0] busy_q, busy_d;
  logic [D-1:0] wa [2];
  logic [W-1:0] wd [2];
  logic [1:0]   wen;
  logic         mark_ok;

  // Effective writes/marks exclude the hardwired zero register.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      wa[i]  = waddr[i*D +: D];
      wd[i]  = wdata[i*W +: W];
      wen[i] = we[i] && !((ZERO_MODE != 0) && (wa[i] == '0));
    end
    mark_ok = mark_en && !((ZERO_MODE != 0) && (mark_addr == '0));
  end

  // Port 1 is applied last so it wins a same-address conflict; a mark overrides a clear.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int i = 0; i < 2; i++) begin
      if (wen[i]) begin
        mem_d[wa[i]]  = wd[i];
        busy_d[wa[i]] = 1'b0;
      end
    end
    if (mark_ok) busy_d[mark_addr] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      mem_q  <= '{default: '0};
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [D-1:0] ra;
    logic [W-1:0] rd;
    logic         bz;

    assign ra = raddr[k*D +: D];

    always_comb begin
      rd = mem_q[ra];
      bz = busy_q[ra];
      if (BYPASS != 0) begin
        for (int i = 0; i < 2; i++) begin
          if (wen[i] && (wa[i] == ra)) begin
            rd = wd[i];
            // A same-cycle mark is not forwarded, so the stored flag stays visible.
            bz = (mark_ok && (mark_addr == ra)) ? busy_q[ra] : 1'b0;
          end
        end
      end
      if ((ZERO_MODE != 0) && (ra == '0)) begin
        rd = '0;
        bz = 1'b0;
      end
    end

    assign rdata[k*W +: W] = rd;
    assign rbusy[k]        = bz;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: three configurations share the write/mark stimulus
// and are compared every cycle against an array-based model, plus literal spot checks.
module tb_reg_file_mp;
  logic        CLK = 1'b0;
  logic        Reset;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [15:0] wdata;
  logic        mark_en;
  logic [4:0]  mark_addr;
  logic [9:0]  ra2;
  logic [19:0] ra4;
  logic [15:0] rdata_a, rdata_b;
  logic [1:0]  rbusy_a, rbusy_b;
  logic [31:0] rdata_c;
  logic [3:0]  rbusy_c;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // mm/bb[z]: model state of a register file with ZERO_MODE = z
  logic [7:0] mm [2][32];
  bit         bb [2][32];

  always #5 CLK = ~CLK;

  reg_file_mp #(.W(8), .D(5), .NR(2), .ZERO_MODE(1), .BYPASS(1)) dut_a (
    .CLK(CLK), .Reset(Reset), .we(we), .waddr(waddr), .wdata(wdata),
    .mark_en(mark_en), .mark_addr(mark_addr), .raddr(ra2),
    .rdata(rdata_a), .rbusy(rbusy_a));

  reg_file_mp #(.W(8), .D(5), .NR(2), .ZERO_MODE(1), .BYPASS(0)) dut_b (
    .CLK(CLK), .Reset(Reset), .we(we), .waddr(waddr), .wdata(wdata),
    .mark_en(mark_en), .mark_addr(mark_addr), .raddr(ra2),
    .rdata(rdata_b), .rbusy(rbusy_b));

  reg_file_mp #(.W(8), .D(5), .NR(4), .ZERO_MODE(0), .BYPASS(1)) dut_c (
    .CLK(CLK), .Reset(Reset), .we(we), .waddr(waddr), .wdata(wdata),
    .mark_en(mark_en), .mark_addr(mark_addr), .raddr(ra4),
    .rdata(rdata_c), .rbusy(rbusy_c));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] wa(input int p);
    return waddr[p*5 +: 5];
  endfunction

  function automatic bit eff(input int z, input int p);
    return we[p] && !(z == 1 && wa(p) == 5'd0);
  endfunction

  function automatic logic [7:0] exp_rd(input int z, input bit byp, input logic [4:0] ra);
    if (z == 1 && ra == 5'd0) return 8'h00;
    if (byp && eff(z, 1) && wa(1) == ra) return wdata[15:8];
    if (byp && eff(z, 0) && wa(0) == ra) return wdata[7:0];
    return mm[z][ra];
  endfunction

  function automatic bit exp_bz(input int z, input bit byp, input logic [4:0] ra);
    bit hit;
    if (z == 1 && ra == 5'd0) return 1'b0;
    hit = (eff(z, 0) && wa(0) == ra) || (eff(z, 1) && wa(1) == ra);
    if (byp && hit && !(mark_en && mark_addr == ra)) return 1'b0;
    return bb[z][ra];
  endfunction

  // Model state update from the inputs present at the edge.
  always @(posedge CLK) begin
    for (int z = 0; z < 2; z++) begin
      if (Reset) begin
        for (int r = 0; r < 32; r++) begin
          mm[z][r] = 8'h00;
          bb[z][r] = 1'b0;
        end
      end else begin
        if (eff(z, 0)) begin mm[z][wa(0)] = wdata[7:0];  bb[z][wa(0)] = 1'b0; end
        if (eff(z, 1)) begin mm[z][wa(1)] = wdata[15:8]; bb[z][wa(1)] = 1'b0; end
        if (mark_en && !(z == 1 && mark_addr == 5'd0)) bb[z][mark_addr] = 1'b1;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en && !Reset) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("a.rdata%0d", k), 32'(rdata_a[k*8 +: 8]), 32'(exp_rd(1, 1'b1, ra2[k*5 +: 5])));
        check($sformatf("a.rbusy%0d", k), 32'(rbusy_a[k]),        32'(exp_bz(1, 1'b1, ra2[k*5 +: 5])));
        check($sformatf("b.rdata%0d", k), 32'(rdata_b[k*8 +: 8]), 32'(exp_rd(1, 1'b0, ra2[k*5 +: 5])));
        check($sformatf("b.rbusy%0d", k), 32'(rbusy_b[k]),        32'(exp_bz(1, 1'b0, ra2[k*5 +: 5])));
      end
      for (int k = 0; k < 4; k++) begin
        check($sformatf("c.rdata%0d", k), 32'(rdata_c[k*8 +: 8]), 32'(exp_rd(0, 1'b1, ra4[k*5 +: 5])));
        check($sformatf("c.rbusy%0d", k), 32'(rbusy_c[k]),        32'(exp_bz(0, 1'b1, ra4[k*5 +: 5])));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    Reset = 1'b1; we = '0; waddr = '0; wdata = '0; mark_en = 1'b0; mark_addr = '0;
    ra2 = '0; ra4 = '0;
    step(); step();
    Reset = 1'b0;
    chk_en = 1'b1;

    // 1. everything reads zero after reset; r0 ignores writes with ZERO_MODE=1
    for (int i = 0; i < 32; i++) begin
      ra2 = {5'(31 - i), 5'(i)};
      ra4 = {5'(i), 5'(i), 5'(31 - i), 5'(i)};
      settle();
      if (i == 0 || i == 17 || i == 31) begin
        check("reset rdata_a", 32'(rdata_a), 32'h0);
        check("reset rbusy_a", 32'(rbusy_a), 32'h0);
      end
      step();
    end
    we = 2'b01; waddr = 10'd0; wdata = 16'h00FF; ra2 = '0; ra4 = '0;
    step();
    we = 2'b00;
    settle();
    check("r0 zero_mode=1", 32'(rdata_a[7:0]), 32'h00);
    check("r0 zero_mode=0", 32'(rdata_c[7:0]), 32'hFF);
    step();

    // 2. bypass vs stored read
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = 16'h00A5; ra2 = {5'd3, 5'd3};
    settle();
    check("bypass a same cycle", 32'(rdata_a[7:0]), 32'hA5);
    check("no bypass b old", 32'(rdata_b[7:0]), 32'h00);
    step();
    we = 2'b00;
    settle();
    check("stored a", 32'(rdata_a[7:0]), 32'hA5);
    check("stored b", 32'(rdata_b[15:8]), 32'hA5);
    step();

    // 3. write conflict: port 1 wins
    we = 2'b11; waddr = {5'd7, 5'd7}; wdata = 16'h2211; ra2 = {5'd3, 5'd7};
    settle();
    check("conflict bypass", 32'(rdata_a[7:0]), 32'h22);
    step();
    we = 2'b00;
    settle();
    check("conflict stored", 32'(rdata_b[7:0]), 32'h22);
    step();

    // 4. busy scoreboard
    mark_en = 1'b1; mark_addr = 5'd9; ra2 = {5'd0, 5'd9};
    step();
    mark_en = 1'b0;
    settle();
    check("busy after mark", 32'(rbusy_a[0]), 32'h1);
    we = 2'b01; waddr = {5'd0, 5'd9}; wdata = 16'h003C;
    settle();
    check("busy cleared by bypass", 32'(rbusy_a[0]), 32'h0);
    check("data bypassed r9", 32'(rdata_a[7:0]), 32'h3C);
    check("busy no bypass b", 32'(rbusy_b[0]), 32'h1);
    step();
    we = 2'b00;
    settle();
    check("busy cleared after edge", 32'(rbusy_a[0]), 32'h0);
    mark_en = 1'b1; we = 2'b01;
    step();
    mark_en = 1'b0; we = 2'b00;
    settle();
    check("mark beats write busy", 32'(rbusy_a[0]), 32'h1);
    check("mark+write data", 32'(rdata_a[7:0]), 32'h3C);
    mark_en = 1'b1; mark_addr = 5'd0; ra4 = '0;
    step();
    mark_en = 1'b0;
    settle();
    check("r0 busy zero_mode=0", 32'(rbusy_c[0]), 32'h1);
    check("r0 busy zero_mode=1", 32'(rbusy_a[1]), 32'h0);
    step();

    // 5. fill, then reset with writes and a mark pending
    for (int i = 1; i < 32; i++) begin
      we = 2'b10; waddr = {5'(i), 5'd0}; wdata = {8'(i), 8'h00};
      step();
    end
    we = 2'b00; ra2 = {5'd31, 5'd5};
    settle();
    check("filled r5", 32'(rdata_a[7:0]), 32'h05);
    check("filled r31", 32'(rdata_b[15:8]), 32'h1F);
    Reset = 1'b1; we = 2'b11; waddr = {5'd6, 5'd5}; wdata = 16'h7766; mark_en = 1'b1; mark_addr = 5'd5;
    step();
    Reset = 1'b0; we = 2'b00; mark_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra2 = {5'(i), 5'(i)};
      ra4 = {5'(31 - i), 5'(i), 5'(i), 5'(i)};
      settle();
      if (i == 5 || i == 6) begin
        check("reset drop data", 32'(rdata_a), 32'h0);
        check("reset drop busy", 32'(rbusy_c), 32'h0);
      end
      step();
    end

    // 6. random regression against the model
    for (int n = 0; n < 10000; n++) begin
      Reset     = ($urandom_range(0, 499) == 0);
      we        = 2'($urandom);
      waddr     = 10'($urandom);
      wdata     = 16'($urandom);
      mark_en   = ($urandom_range(0, 3) == 0);
      mark_addr = 5'($urandom);
      ra2       = 10'($urandom);
      ra4       = 20'($urandom);
      if ($urandom_range(0, 3) == 0) ra2[4:0] = waddr[4:0];
      if ($urandom_range(0, 3) == 0) ra4[9:5] = waddr[9:5];
      if ($urandom_range(0, 7) == 0) waddr[9:5] = waddr[4:0];
      if ($urandom_range(0, 7) == 0) mark_addr = waddr[4:0];
      step();
    end

    Reset = 1'b0; we = '0; mark_en = 1'b0;
    step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
